ex_service_ctrl: RTL and testbench

- Central exception service controller; the consumer side of the per-thread CSR exception interface.
- Watches every thread's csr_stall, ex_cause and cause_thr. Picks one stalled thread at a time by round-robin and presents its exception to the host/debug side with a valid/ready handshake.
- After the host accepts, it pulses clr_ex to that thread's CSR and confirms the stall has dropped before it grants the next thread.

---
 rtl/ex_service_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ex_service_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_service_ctrl.sv
// Exception service controller: round-robin picks one stalled thread, reports its
// cause to the host over valid/ready, pulses clr_ex to that thread, then waits for
// the stall to drop (bounded by TIMEOUT) before the next grant.
// Latency: ex_valid one cycle after a stall is sampled in IDLE; 4-cycle minimum service period.
// Backpressure: ex_ready low holds REPORT indefinitely with ex_code/ex_thr frozen.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   csr_stall       per-thread exception-pending flags
//   ex_cause        packed per-thread 6-bit cause codes
//   cause_thr       packed per-thread 8-bit thread ids
//   clr_ex          one-hot single-cycle clear pulse to the serviced thread
//   ex_valid/ready  host handshake for the captured record
//   ex_code, ex_thr captured record
//   ex_count        saturating count of accepted records
//   timeout_err     sticky flag: a thread kept its stall past TIMEOUT after clr_ex
//   busy            controller is not idle
module ex_service_ctrl #(
    parameter int NUM_THR = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_THR-1:0]     csr_stall,
    input  logic [6*NUM_THR-1:0]   ex_cause,
    input  logic [8*NUM_THR-1:0]   cause_thr,
    output logic [NUM_THR-1:0]     clr_ex,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [5:0]             ex_code,
    output logic [7:0]             ex_thr,
    output logic [15:0]            ex_count,
    output logic                   timeout_err,
    output logic                   busy
);

    localparam int SW = (NUM_THR > 1) ? $clog2(NUM_THR) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REPORT, CLEAR, DRAIN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [SW-1:0]   r_rr_ptr;
    logic [SW-1:0]   r_sel;
    logic [5:0]      r_code;
    logic [7:0]      r_thr;
    logic [15:0]     r_ex_count;
    logic            r_timeout_err;
    logic [TW-1:0]   r_timer;

    logic [SW-1:0]   w_grant;
    logic            w_found;
    logic            w_sel_stall;
    logic            w_timer_done;
    logic [5:0]      w_cause_arr [NUM_THR];
    logic [7:0]      w_thr_arr   [NUM_THR];

    // Unpack the per-thread fields so they can be selected by a narrow index.
    for (genvar g = 0; g < NUM_THR; g++) begin : g_unpack
        assign w_cause_arr[g] = ex_cause[6*g +: 6];
        assign w_thr_arr[g]   = cause_thr[8*g +: 8];
    end

    assign w_sel_stall  = csr_stall[r_sel];
    // Timer counts completed DRAIN cycles with stall still high; the TIMEOUT-th one gives up.
    assign w_timer_done = (r_timer == TW'(TIMEOUT - 1));

    // Round-robin search: first pending thread at offsets 0..NUM_THR-1 from r_rr_ptr.
    always_comb begin
        logic [SW:0] w_sum;
        w_sum   = '0;
        w_found = 1'b0;
        w_grant = '0;
        for (int i = 0; i < NUM_THR; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (SW+1)'(i);
            if (w_sum >= (SW+1)'(NUM_THR)) begin
                w_sum = w_sum - (SW+1)'(NUM_THR);
            end
            if (!w_found && csr_stall[w_sum[SW-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_sum[SW-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_next = REPORT;
            REPORT:  if (ex_ready) w_next = CLEAR;
            CLEAR:   w_next = DRAIN;
            DRAIN:   if (!w_sel_stall || w_timer_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are decoded from state only, so reset clears them asynchronously.
    always_comb begin
        clr_ex   = '0;
        ex_valid = (r_state == REPORT);
        busy     = (r_state != IDLE);
        if (r_state == CLEAR) begin
            clr_ex[r_sel] = 1'b1;
        end
    end

    assign ex_code     = r_code;
    assign ex_thr      = r_thr;
    assign ex_count    = r_ex_count;
    assign timeout_err = r_timeout_err;

    // Datapath: capture, counter, pointer advance, drain timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_sel         <= '0;
            r_code        <= '0;
            r_thr         <= '0;
            r_ex_count    <= '0;
            r_timeout_err <= 1'b0;
            r_timer       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_sel  <= w_grant;
                        r_code <= w_cause_arr[w_grant];
                        r_thr  <= w_thr_arr[w_grant];
                    end
                end
                REPORT: begin
                    if (ex_ready && (r_ex_count != 16'hFFFF)) begin
                        r_ex_count <= r_ex_count + 16'd1;
                    end
                end
                CLEAR: begin
                    // Pointer moves past the serviced thread so it goes to the back of the line.
                    r_rr_ptr <= (r_sel == SW'(NUM_THR - 1)) ? '0 : r_sel + 1'b1;
                    r_timer  <= '0;
                end
                DRAIN: begin
                    if (w_sel_stall) begin
                        if (w_timer_done) begin
                            r_timeout_err <= 1'b1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_service_ctrl.sv
module tb_ex_service_ctrl;

    localparam int N  = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    csr_stall;
    logic [6*N-1:0]  ex_cause;
    logic [8*N-1:0]  cause_thr;
    logic [N-1:0]    clr_ex;
    logic            ex_valid;
    logic            ex_ready;
    logic [5:0]      ex_code;
    logic [7:0]      ex_thr;
    logic [15:0]     ex_count;
    logic            timeout_err;
    logic            busy;

    always #5 clk = ~clk;

    ex_service_ctrl #(.NUM_THR(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .csr_stall(csr_stall), .ex_cause(ex_cause),
        .cause_thr(cause_thr), .clr_ex(clr_ex), .ex_valid(ex_valid),
        .ex_ready(ex_ready), .ex_code(ex_code), .ex_thr(ex_thr),
        .ex_count(ex_count), .timeout_err(timeout_err), .busy(busy)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_ptr;
    int          m_cnt;
    int          lat;
    int          drain;
    logic [N-1:0] stuck;
    logic [N-1:0] s_clr;
    logic [5:0]  codes [N];
    logic [7:0]  ids   [N];
    logic [5:0]  hold_code;
    logic [7:0]  hold_thr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; the CSR model drops a thread's stall on the edge ending its clr_ex
    // pulse unless that thread is marked stuck.
    task automatic tick();
        @(negedge clk);
        s_clr = clr_ex;
        chk("clr_onehot0", 32'($onehot0(clr_ex)), 32'd1);
        @(posedge clk);
        #1;
        csr_stall = csr_stall & ~(s_clr & ~stuck);
    endtask

    function automatic int rr_pick(input logic [N-1:0] p, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (p[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_thr(input int t, input logic [5:0] c, input logic [7:0] id);
        codes[t] = c;
        ids[t]   = id;
        ex_cause[6*t +: 6]  = c;
        cause_thr[8*t +: 8] = id;
    endtask

    task automatic wait_valid();
        lat = 0;
        while (!ex_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("valid_seen", 32'(ex_valid), 32'd1);
    endtask

    // Service the next thread the round-robin model predicts, optionally holding
    // ex_ready low for 'hold' cycles once the record is shown.
    task automatic serve_next(input string tag, input int hold);
        int t;
        t = rr_pick(csr_stall, m_ptr);
        if (t < 0) begin
            chk({tag, "_pending"}, 32'(csr_stall), 32'd1);
            return;
        end
        if (hold > 0) ex_ready = 1'b0;
        wait_valid();
        chk({tag, "_thr"}, 32'(ex_thr), 32'(ids[t]));
        chk({tag, "_code"}, 32'(ex_code), 32'(codes[t]));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int k = 0; k < hold; k++) begin
            tick();
            chk({tag, "_hold_valid"}, 32'(ex_valid), 32'd1);
            chk({tag, "_hold_clr"}, 32'(clr_ex), 32'd0);
        end
        ex_ready = 1'b1;
        tick();
        chk({tag, "_clr"}, 32'(clr_ex), 32'(1 << t));
        chk({tag, "_valid_low"}, 32'(ex_valid), 32'd0);
        m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
        m_ptr = (t + 1) % N;
        chk({tag, "_count"}, 32'(ex_count), 32'(m_cnt));
        tick();
        chk({tag, "_clr_once"}, 32'(clr_ex), 32'd0);
        drain = 0;
        while (busy && drain < 40) begin
            tick();
            drain++;
        end
        chk({tag, "_drain"}, 32'(drain), stuck[t] ? 32'(TO) : 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        csr_stall = '0;
        ex_cause  = '0;
        cause_thr = '0;
        ex_ready  = 1'b0;
        stuck     = '0;
        for (int i = 0; i < N; i++) begin
            codes[i] = '0;
            ids[i]   = '0;
        end
        m_ptr = 0;
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_clr", 32'(clr_ex), 32'd0);
        chk("rst_code", 32'(ex_code), 32'd0);
        chk("rst_thr", 32'(ex_thr), 32'd0);
        chk("rst_count", 32'(ex_count), 32'd0);
        chk("rst_toerr", 32'(timeout_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Round-robin over 1011 from pointer 0: threads 0, 1, 3.
        set_thr(0, 6'h11, 8'hA0);
        set_thr(1, 6'h12, 8'hA1);
        set_thr(3, 6'h13, 8'hA3);
        ex_ready  = 1'b1;
        csr_stall = 4'b1011;
        serve_next("rr0", 0);
        serve_next("rr1", 0);
        serve_next("rr3", 0);
        chk("rr_count", 32'(ex_count), 32'd3);
        chk("rr_idle", 32'(busy), 32'd0);
        chk("rr_stall_empty", 32'(csr_stall), 32'd0);

        // Single exception on thread 2 with one-cycle report latency.
        set_thr(2, 6'h05, 8'h02);
        csr_stall = 4'b0100;
        serve_next("single", 0);
        chk("single_latency", 32'(lat), 32'd1);
        chk("single_count", 32'(ex_count), 32'd4);

        // Backpressure on thread 3 (pointer now 3) while the cause inputs churn.
        set_thr(3, 6'h2A, 8'h33);
        ex_ready  = 1'b0;
        csr_stall = 4'b1000;
        wait_valid();
        hold_code = ex_code;
        hold_thr  = ex_thr;
        chk("bp_code", 32'(hold_code), 32'h2A);
        for (int k = 0; k < 10; k++) begin
            ex_cause  = 24'($urandom);
            cause_thr = $urandom;
            tick();
            chk("bp_valid", 32'(ex_valid), 32'd1);
            chk("bp_code_stable", 32'(ex_code), 32'h2A);
            chk("bp_thr_stable", 32'(ex_thr), 32'h33);
            chk("bp_no_clr", 32'(clr_ex), 32'd0);
            chk("bp_count_hold", 32'(ex_count), 32'(m_cnt));
        end
        serve_next("bp", 0);
        chk("bp_count_once", 32'(ex_count), 32'd5);

        // Timeout: thread 1 ignores clr_ex; thread 2 must be served before it returns.
        set_thr(1, 6'h21, 8'h51);
        set_thr(2, 6'h22, 8'h52);
        stuck     = 4'b0010;
        csr_stall = 4'b0110;
        serve_next("to_stuck", 0);
        chk("to_err_set", 32'(timeout_err), 32'd1);
        chk("to_still_pending", 32'(csr_stall), 32'h6);
        stuck = '0;
        serve_next("to_other", 0);
        chk("to_other_was2", 32'(ex_thr), 32'h52);
        chk("to_err_sticky1", 32'(timeout_err), 32'd1);
        serve_next("to_again", 0);
        chk("to_again_was1", 32'(ex_thr), 32'h51);
        chk("to_err_sticky2", 32'(timeout_err), 32'd1);

        // Reset mid-REPORT: pointer is 2 so thread 2 is granted; after reset thread 1 goes first.
        set_thr(1, 6'h31, 8'h61);
        set_thr(2, 6'h32, 8'h62);
        ex_ready  = 1'b0;
        csr_stall = 4'b0110;
        wait_valid();
        chk("mr_pre_thr", 32'(ex_thr), 32'h62);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_valid", 32'(ex_valid), 32'd0);
        chk("mr_clr", 32'(clr_ex), 32'd0);
        chk("mr_count", 32'(ex_count), 32'd0);
        chk("mr_toerr", 32'(timeout_err), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mr_hold_clr", 32'(clr_ex), 32'd0);
        end
        rst   = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
        serve_next("mr_first", 2);
        chk("mr_first_was1", 32'(ex_thr), 32'h61);
        serve_next("mr_second", 0);
        chk("mr_second_was2", 32'(ex_thr), 32'h62);

        // Randomized rounds against the round-robin model.
        for (int r = 0; r < 8; r++) begin
            for (int t = 0; t < N; t++) begin
                set_thr(t, 6'($urandom), 8'($urandom));
            end
            csr_stall = 4'($urandom_range(1, 15));
            for (int g = 0; g < N && csr_stall != 0; g++) begin
                serve_next("rand", int'($urandom_range(0, 3)));
            end
            chk("rand_done", 32'(csr_stall), 32'd0);
        end

        // Counter saturation from a preloaded 16'hFFFE.
        force dut.r_ex_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_ex_count;
        @(posedge clk);
        #1;
        m_cnt = 65534;
        chk("sat_preload", 32'(ex_count), 32'hFFFE);
        set_thr(0, 6'h01, 8'h10);
        set_thr(1, 6'h02, 8'h11);
        set_thr(2, 6'h03, 8'h12);
        csr_stall = 4'b0111;
        serve_next("sat1", 0);
        serve_next("sat2", 0);
        serve_next("sat3", 0);
        chk("sat_final", 32'(ex_count), 32'hFFFF);
        chk("sat_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
